term_cmd_sequencer: RTL and testbench

Sequences all writes to the character buffer write port and all changes to the cursor position for the VT52-style terminal. It accepts one decoded terminal command at a time (printable char, cursor motion, VT52 erase operations) over a valid/ready handshake. It owns the cursor_x/cursor_y registers. Multi-cell erases run as an internal fill sweep while the command port is stalled. It sits between the keyboard/escape decoder and char_generator/cursor_blinker, replacing ad-hoc write-enable juggling in top.

---
 rtl/term_cmd_sequencer.sv | 159 +++++++++++++++
 tb/tb_term_cmd_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/term_cmd_sequencer.sv
// Command sequencer for the VT52-style terminal: owns the cursor position and
// serialises every character buffer write, including multi-cell erase sweeps.
module term_cmd_sequencer #(
  parameter int unsigned COL_BITS  = 6,
  parameter int unsigned ROW_BITS  = 4,
  parameter logic [7:0]  FILL_CHAR = 8'h20
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [3:0]                   cmd_op,
  input  logic [7:0]                   cmd_char,
  output logic [COL_BITS-1:0]          cursor_x,
  output logic [ROW_BITS-1:0]          cursor_y,
  output logic                         cursor_wr,
  output logic [COL_BITS+ROW_BITS-1:0] buf_addr,
  output logic [7:0]                   buf_data,
  output logic                         buf_wen
);

  localparam int unsigned ADDR_W = COL_BITS + ROW_BITS;
  localparam logic [COL_BITS-1:0] XMAX = '1;
  localparam logic [ROW_BITS-1:0] YMAX = '1;

  localparam logic [3:0] OP_PUTC    = 4'd1;
  localparam logic [3:0] OP_BS      = 4'd2;
  localparam logic [3:0] OP_CR      = 4'd3;
  localparam logic [3:0] OP_LF      = 4'd4;
  localparam logic [3:0] OP_UP      = 4'd5;
  localparam logic [3:0] OP_DOWN    = 4'd6;
  localparam logic [3:0] OP_LEFT    = 4'd7;
  localparam logic [3:0] OP_RIGHT   = 4'd8;
  localparam logic [3:0] OP_HOME    = 4'd9;
  localparam logic [3:0] OP_EOL     = 4'd10;
  localparam logic [3:0] OP_EOS     = 4'd11;
  localparam logic [3:0] OP_CLEAR   = 4'd12;
  localparam logic [3:0] OP_NEWLINE = 4'd13;

  typedef enum logic {IDLE, FILL} state_e;

  state_e              state_q;
  logic [COL_BITS-1:0] x_q;
  logic [ROW_BITS-1:0] y_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [ADDR_W-1:0]   end_q;
  logic [7:0]          data_q;
  logic                wen_q;
  logic                cwr_q;
  logic                accept_c;

  assign cmd_ready = (state_q == IDLE) & clr;
  assign accept_c  = cmd_valid & cmd_ready;

  assign cursor_x  = x_q;
  assign cursor_y  = y_q;
  assign cursor_wr = cwr_q;
  assign buf_addr  = addr_q;
  assign buf_data  = data_q;
  assign buf_wen   = wen_q;

  // Command execution and erase sweep; motion saturates at the screen edges.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      end_q   <= '0;
      data_q  <= '0;
      wen_q   <= 1'b0;
      cwr_q   <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      cwr_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept_c) begin
            case (cmd_op)
              OP_PUTC: begin
                addr_q <= {y_q, x_q};
                data_q <= cmd_char;
                wen_q  <= 1'b1;
                cwr_q  <= 1'b1;
                if (x_q != XMAX) x_q <= x_q + COL_BITS'(1);
              end
              OP_BS, OP_LEFT: begin
                cwr_q <= 1'b1;
                if (x_q != '0) x_q <= x_q - COL_BITS'(1);
              end
              OP_RIGHT: begin
                cwr_q <= 1'b1;
                if (x_q != XMAX) x_q <= x_q + COL_BITS'(1);
              end
              OP_CR: begin
                cwr_q <= 1'b1;
                x_q   <= '0;
              end
              OP_LF, OP_DOWN: begin
                cwr_q <= 1'b1;
                if (y_q != YMAX) y_q <= y_q + ROW_BITS'(1);
              end
              OP_UP: begin
                cwr_q <= 1'b1;
                if (y_q != '0) y_q <= y_q - ROW_BITS'(1);
              end
              OP_HOME: begin
                cwr_q <= 1'b1;
                x_q   <= '0;
                y_q   <= '0;
              end
              OP_NEWLINE: begin
                cwr_q <= 1'b1;
                x_q   <= '0;
                if (y_q != YMAX) y_q <= y_q + ROW_BITS'(1);
              end
              OP_EOL: begin
                state_q <= FILL;
                addr_q  <= {y_q, x_q};
                end_q   <= {y_q, XMAX};
                data_q  <= FILL_CHAR;
                wen_q   <= 1'b1;
              end
              OP_EOS: begin
                state_q <= FILL;
                addr_q  <= {y_q, x_q};
                end_q   <= '1;
                data_q  <= FILL_CHAR;
                wen_q   <= 1'b1;
              end
              OP_CLEAR: begin
                state_q <= FILL;
                cwr_q   <= 1'b1;
                x_q     <= '0;
                y_q     <= '0;
                addr_q  <= '0;
                end_q   <= '1;
                data_q  <= FILL_CHAR;
                wen_q   <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        FILL: begin
          // Plain binary increment lets the last column carry into the next row.
          if (addr_q == end_q) begin
            state_q <= IDLE;
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
            wen_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_term_cmd_sequencer.sv
// Bench for term_cmd_sequencer: vector table, directed corner sequences and
// randomized commands checked against a cursor/write-list reference model.
module tb_term_cmd_sequencer;

  logic       clk = 1'b0;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [7:0] cmd_char;
  logic [5:0] cursor_x;
  logic [3:0] cursor_y;
  logic       cursor_wr;
  logic [9:0] buf_addr;
  logic [7:0] buf_data;
  logic       buf_wen;

  always #5 clk = ~clk;

  term_cmd_sequencer dut (
    .clk       (clk),
    .clr       (clr),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_char  (cmd_char),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .cursor_wr (cursor_wr),
    .buf_addr  (buf_addr),
    .buf_data  (buf_data),
    .buf_wen   (buf_wen)
  );

  int errors = 0;
  int checks = 0;
  logic rdy_seen;

  // Reference model: cursor as integers, pending fill writes as an address queue.
  int mx = 0, my = 0, maddr = 0, mdata = 0;
  bit mwen = 0, mwr = 0, mfill = 0;
  int pend[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic start_fill(input int s, input int e);
    for (int a = s; a <= e; a++) pend.push_back(a);
    maddr = pend.pop_front();
    mdata = 32;
    mwen  = 1;
    mfill = 1;
  endtask

  task automatic model_edge(input int op, input int ch, input bit c, input bit acc);
    if (!c) begin
      mx = 0; my = 0; maddr = 0; mdata = 0; mwen = 0; mwr = 0; mfill = 0;
      pend.delete();
      return;
    end
    mwen = 0;
    mwr  = 0;
    if (mfill) begin
      if (pend.size() > 0) begin
        maddr = pend.pop_front();
        mwen  = 1;
      end else begin
        mfill = 0;
      end
    end else if (acc) begin
      case (op)
        1: begin
          maddr = my * 64 + mx; mdata = ch; mwen = 1; mwr = 1;
          mx = (mx < 63) ? mx + 1 : 63;
        end
        2, 7: begin mx = (mx > 0) ? mx - 1 : 0; mwr = 1; end
        3: begin mx = 0; mwr = 1; end
        4, 6: begin my = (my < 15) ? my + 1 : 15; mwr = 1; end
        5: begin my = (my > 0) ? my - 1 : 0; mwr = 1; end
        8: begin mx = (mx < 63) ? mx + 1 : 63; mwr = 1; end
        9: begin mx = 0; my = 0; mwr = 1; end
        10: start_fill(my * 64 + mx, my * 64 + 63);
        11: start_fill(my * 64 + mx, 1023);
        12: begin mx = 0; my = 0; mwr = 1; start_fill(0, 1023); end
        13: begin mx = 0; my = (my < 15) ? my + 1 : 15; mwr = 1; end
        default: ;
      endcase
    end
  endtask

  // One clock cycle: drive, check ready, clock, check registered outputs.
  task automatic step(input bit v, input int op, input int ch, input bit c);
    bit acc;
    cmd_valid = v;
    cmd_op    = 4'(op);
    cmd_char  = 8'(ch);
    clr       = c;
    #1;
    rdy_seen = cmd_ready;
    chk("cmd_ready", int'(cmd_ready), (c && !mfill) ? 1 : 0);
    acc = v && c && !mfill;
    @(posedge clk);
    model_edge(op, ch, c, acc);
    #1;
    chk("cursor_x", int'(cursor_x), mx);
    chk("cursor_y", int'(cursor_y), my);
    chk("cursor_wr", int'(cursor_wr), int'(mwr));
    chk("buf_wen", int'(buf_wen), int'(mwen));
    chk("buf_addr", int'(buf_addr), maddr);
    chk("buf_data", int'(buf_data), mdata);
    @(negedge clk);
  endtask

  task automatic goto_xy(input int x, input int y);
    step(1, 9, 0, 1);
    for (int i = 0; i < x; i++) step(1, 8, 0, 1);
    for (int i = 0; i < y; i++) step(1, 6, 0, 1);
  endtask

  typedef struct {
    bit v; int op; int ch;
    int x; int y; bit wen; int addr; int data; bit wr;
  } vec_t;

  vec_t tbl[17];

  initial begin
    int nlow, nwen;
    bit done;

    tbl[0]  = '{1, 1,  'h61, 1, 0, 1, 0,  'h61, 1};
    tbl[1]  = '{1, 1,  'h62, 2, 0, 1, 1,  'h62, 1};
    tbl[2]  = '{1, 0,  0,    2, 0, 0, 1,  'h62, 0};
    tbl[3]  = '{1, 4,  0,    2, 1, 0, 1,  'h62, 1};
    tbl[4]  = '{1, 2,  0,    1, 1, 0, 1,  'h62, 1};
    tbl[5]  = '{1, 5,  0,    1, 0, 0, 1,  'h62, 1};
    tbl[6]  = '{1, 5,  0,    1, 0, 0, 1,  'h62, 1};
    tbl[7]  = '{1, 7,  0,    0, 0, 0, 1,  'h62, 1};
    tbl[8]  = '{1, 7,  0,    0, 0, 0, 1,  'h62, 1};
    tbl[9]  = '{1, 8,  0,    1, 0, 0, 1,  'h62, 1};
    tbl[10] = '{1, 6,  0,    1, 1, 0, 1,  'h62, 1};
    tbl[11] = '{1, 1,  'h51, 2, 1, 1, 65, 'h51, 1};
    tbl[12] = '{1, 3,  0,    0, 1, 0, 65, 'h51, 1};
    tbl[13] = '{1, 15, 0,    0, 1, 0, 65, 'h51, 0};
    tbl[14] = '{1, 13, 0,    0, 2, 0, 65, 'h51, 1};
    tbl[15] = '{1, 9,  0,    0, 0, 0, 65, 'h51, 1};
    tbl[16] = '{0, 1,  'h55, 0, 0, 0, 65, 'h51, 0};

    // Reset state
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_x", int'(cursor_x), 0);
    chk("rst_y", int'(cursor_y), 0);
    chk("rst_wen", int'(buf_wen), 0);
    chk("rst_addr", int'(buf_addr), 0);
    chk("rst_data", int'(buf_data), 0);
    chk("rst_wr", int'(cursor_wr), 0);

    for (int i = 0; i < 17; i++) begin
      step(tbl[i].v, tbl[i].op, tbl[i].ch, 1);
      chk($sformatf("tbl%0d_x", i), int'(cursor_x), tbl[i].x);
      chk($sformatf("tbl%0d_y", i), int'(cursor_y), tbl[i].y);
      chk($sformatf("tbl%0d_wen", i), int'(buf_wen), int'(tbl[i].wen));
      chk($sformatf("tbl%0d_addr", i), int'(buf_addr), tbl[i].addr);
      chk($sformatf("tbl%0d_data", i), int'(buf_data), tbl[i].data);
      chk($sformatf("tbl%0d_wr", i), int'(cursor_wr), int'(tbl[i].wr));
    end

    // Bottom-right corner saturation
    goto_xy(70, 20);
    step(1, 8, 0, 1);
    step(1, 6, 0, 1);
    step(1, 1, 'h7a, 1);
    chk("corner_addr", int'(buf_addr), 1023);
    chk("corner_data", int'(buf_data), 'h7a);
    chk("corner_x", int'(cursor_x), 63);
    chk("corner_y", int'(cursor_y), 15);

    // Erase to end of line with a PUTC held pending
    goto_xy(60, 3);
    step(1, 10, 0, 1);
    chk("eol_first_addr", int'(buf_addr), 252);
    chk("eol_first_data", int'(buf_data), 'h20);
    nlow = 0; nwen = 1; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step(1, 1, 'h6b, 1);
      if (rdy_seen) done = 1;
      else begin
        nlow++;
        if (buf_wen) nwen++;
      end
    end
    chk("eol_done", int'(done), 1);
    chk("eol_ready_low", nlow, 4);
    chk("eol_wen_cycles", nwen, 4);
    chk("eol_putc_addr", int'(buf_addr), 252);
    chk("eol_putc_data", int'(buf_data), 'h6b);
    chk("eol_cursor_x", int'(cursor_x), 61);

    // Full clear
    goto_xy(5, 7);
    step(1, 12, 0, 1);
    chk("clr_x", int'(cursor_x), 0);
    chk("clr_y", int'(cursor_y), 0);
    chk("clr_wr", int'(cursor_wr), 1);
    nlow = 0; nwen = 1; done = 0;
    for (int i = 0; i < 1100 && !done; i++) begin
      step(0, 0, 0, 1);
      if (!rdy_seen) nlow++;
      if (buf_wen) nwen++;
      else done = 1;
    end
    chk("clr_done", int'(done), 1);
    chk("clr_wen_cycles", nwen, 1024);
    chk("clr_ready_low", nlow, 1024);
    step(0, 0, 0, 1);
    chk("clr_ready_after", int'(rdy_seen), 1);

    // Clear aborted by reset mid-sweep
    goto_xy(9, 2);
    step(1, 12, 0, 1);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1);
    chk("abort_wen_before", int'(buf_wen), 1);
    step(0, 0, 0, 0);
    chk("abort_wen", int'(buf_wen), 0);
    chk("abort_x", int'(cursor_x), 0);
    chk("abort_y", int'(cursor_y), 0);
    step(0, 0, 0, 0);
    chk("abort_ready_in_rst", int'(rdy_seen), 0);
    step(0, 0, 0, 1);
    chk("abort_ready_release", int'(rdy_seen), 1);

    // Newline, backspace at column 0, reserved opcode
    goto_xy(40, 15);
    step(1, 13, 0, 1);
    chk("nl_x", int'(cursor_x), 0);
    chk("nl_y", int'(cursor_y), 15);
    chk("nl_wr", int'(cursor_wr), 1);
    step(1, 2, 0, 1);
    chk("bs_x", int'(cursor_x), 0);
    chk("bs_y", int'(cursor_y), 15);
    chk("bs_wr", int'(cursor_wr), 1);
    step(1, 14, 0, 1);
    chk("op14_wr", int'(cursor_wr), 0);
    chk("op14_wen", int'(buf_wen), 0);
    chk("op14_x", int'(cursor_x), 0);

    // Randomized commands with occasional resets
    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, 15)),
           int'($urandom_range(0, 255)), $urandom_range(0, 199) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
